// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 32;

    localparam logic [PC_W-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [PC_W-1:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [PC_W-1:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_next_pc_sel.sv
// Next fetch address: redirect target, sequential step, or hold.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            capture,
    output logic [PC_W-1:0] next_pc_c
);

    // Redirect wins; the sequential add wraps naturally at 2^32.
    always_comb begin
        next_pc_c = pc;
        if (redirect) begin
            next_pc_c = redirect_target;
        end else if (capture) begin
            next_pc_c = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch with IF/ID register, redirect, stall and halt on EBREAK.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [fetch_pkg::PC_W-1:0] PC_out,
    input  logic [fetch_pkg::PC_W-1:0] instruction,
    input  logic                       redirect_valid,
    input  logic [fetch_pkg::PC_W-1:0] redirect_target,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [fetch_pkg::PC_W-1:0] if_pc,
    output logic [fetch_pkg::PC_W-1:0] if_instr,
    output logic                       fetch_fault,
    output logic                       halted,
    output logic [fetch_pkg::CNT_W-1:0] fetch_count
);

    import fetch_pkg::*;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    if_id_t           ifid_q, ifid_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_q, fault_d;
    logic             halted_q, halted_d;

    logic in_boot;
    logic redirect_ok;
    logic redirect_bad;
    logic capture;

    // Redirects are only honoured once out of BOOT and only when word aligned.
    assign in_boot      = (state_q == BOOT);
    assign redirect_ok  = redirect_valid && !in_boot && (redirect_target[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && !in_boot && (redirect_target[1:0] != 2'b00);
    assign capture      = (state_q == FETCH) && !redirect_ok && (!valid_q || if_ready);

    next_pc_sel u_next_pc_sel (
        .pc              (pc_q),
        .redirect        (redirect_ok),
        .redirect_target (redirect_target),
        .capture         (capture),
        .next_pc_c       (pc_d)
    );

    // Next-state and IF/ID update
    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        valid_d = valid_q;
        count_d = count_q;
        fault_d = redirect_bad;

        if (redirect_ok) begin
            state_d      = FETCH;
            valid_d      = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (capture) begin
                        ifid_d.pc    = pc_q;
                        ifid_d.instr = instruction;
                        valid_d      = 1'b1;
                        count_d      = count_q + CNT_W'(1);
                        if (instruction == EBREAK_INSTR) begin
                            state_d = HALTED;
                        end
                    end
                end
                HALTED: begin
                    if (if_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            ifid_q   <= '{pc: '0, instr: NOP_INSTR};
            valid_q  <= 1'b0;
            count_q  <= '0;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
            halted_q <= halted_d;
        end
    end

    assign PC_out      = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = ifid_q.pc;
    assign if_instr    = ifid_q.instr;
    assign fetch_fault = fault_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios, then randomized traffic vs a reference model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } status_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc_out, instruction, redirect_target, if_pc, if_instr, fetch_count;
    logic        redirect_valid, if_valid, if_ready, fetch_fault, halted;

    logic [31:0] w_pc_out, w_instruction, w_if_pc, w_if_instr, w_fetch_count;
    logic        w_if_valid, w_fetch_fault, w_halted;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    status_t st_q[$];
    xfer_t   sb_q[$];

    // Reference model state (mirrors what the outputs should show this cycle)
    logic        m_boot, m_valid, m_halt, m_fault;
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;

    // Program image: a few fixed words, everything else derived from the address.
    function automatic logic [31:0] mem_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0008,
            32'h0000_0048,
            32'h0000_00C4: return EBRK;
            default:       return {a[24:0], 7'h13};
        endcase
    endfunction

    assign instruction   = mem_at(pc_out);
    assign w_instruction = mem_at(w_pc_out);

    instruction_fetch u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC_out          (pc_out),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fetch_fault     (fetch_fault),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC_out          (w_pc_out),
        .instruction     (w_instruction),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .if_valid        (w_if_valid),
        .if_ready        (1'b1),
        .if_pc           (w_if_pc),
        .if_instr        (w_if_instr),
        .fetch_fault     (w_fetch_fault),
        .halted          (w_halted),
        .fetch_count     (w_fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle status and delivered-instruction scoreboard
    always @(negedge clk) begin
        status_t e;
        xfer_t   x;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("st_pc_out", pc_out, e.pc);
            chk("st_if_valid", 32'(if_valid), 32'(e.valid));
            chk("st_if_pc", if_pc, e.ipc);
            chk("st_if_instr", if_instr, e.instr);
            chk("st_halted", 32'(halted), 32'(e.halted));
            chk("st_fault", 32'(fetch_fault), 32'(e.fault));
            chk("st_count", fetch_count, e.cnt);
        end
        if (mon_en && if_valid && if_ready) begin
            if (sb_q.size() == 0) begin
                chk("xfer_unexpected", 32'(1), 32'(0));
            end else begin
                x = sb_q.pop_front();
                chk("xfer_pc", if_pc, x.pc);
                chk("xfer_instr", if_instr, x.instr);
            end
        end
    end

    // One clock edge of the reference model, given this cycle's inputs.
    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] tgt);
        logic        go, bad;
        logic [31:0] w;
        go  = rv && !m_boot && (tgt[1:0] == 2'b00);
        bad = rv && !m_boot && (tgt[1:0] != 2'b00);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (go) begin
            if (m_valid && !rdy) void'(sb_q.pop_back());
            m_pc    = tgt;
            m_valid = 1'b0;
            m_instr = NOP;
            m_halt  = 1'b0;
        end else if (m_halt) begin
            if (rdy) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            w = mem_at(m_pc);
            sb_q.push_back('{pc: m_pc, instr: w});
            m_ipc   = m_pc;
            m_instr = w;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
            if (w == EBRK) m_halt = 1'b1;
        end
        m_fault = bad;
    endtask

    initial begin
        logic        rdy, rv;
        logic [31:0] tgt;

        rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        #12;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_wrap_pc", w_pc_out, 32'hFFFF_FFFC);

        @(negedge clk); rst_n = 1'b1;
        step();
        chk("boot_pc", pc_out, 32'h0);
        chk("boot_valid", 32'(if_valid), 32'h0);
        step();
        chk("cap0_valid", 32'(if_valid), 32'h1);
        chk("cap0_pc", if_pc, 32'h0);
        chk("cap0_instr", if_instr, 32'h0050_0093);
        chk("cap0_pc_out", pc_out, 32'h4);
        chk("cap0_count", fetch_count, 32'h1);
        chk("wrap_first_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_out", w_pc_out, 32'h0);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc_out", pc_out, 32'h4);
            chk("stall_if_pc", if_pc, 32'h0);
            chk("stall_instr", if_instr, 32'h0050_0093);
            chk("stall_count", fetch_count, 32'h1);
            if (i == 0) chk("wrap_second_pc", w_if_pc, 32'h0);
        end

        if_ready = 1'b1;
        step();
        chk("resume_if_pc", if_pc, 32'h4);
        chk("resume_instr", if_instr, 32'h0000_0213);
        chk("resume_pc_out", pc_out, 32'h8);
        chk("resume_count", fetch_count, 32'h2);

        if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("redir_pc_out", pc_out, 32'h100);
        chk("redir_valid", 32'(if_valid), 32'h0);
        chk("redir_instr", if_instr, NOP);
        if_ready = 1'b1;
        step();
        chk("redir_if_pc", if_pc, 32'h100);
        chk("redir_cap_valid", 32'(if_valid), 32'h1);

        redirect_valid = 1'b1; redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
        chk("mis_fault", 32'(fetch_fault), 32'h1);
        chk("mis_pc_out", pc_out, 32'h108);
        step();
        chk("mis_fault_drop", 32'(fetch_fault), 32'h0);
        chk("mis_pc_seq", pc_out, 32'h10C);

        redirect_valid = 1'b1; redirect_target = 32'h8;
        step();
        redirect_valid = 1'b0;
        step();
        chk("halt_if_pc", if_pc, 32'h8);
        chk("halt_instr", if_instr, EBRK);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc_out", pc_out, 32'hC);
        step();
        step();
        chk("halt_drained", 32'(if_valid), 32'h0);
        chk("halt_hold_pc", pc_out, 32'hC);
        chk("halt_hold_flag", 32'(halted), 32'h1);

        redirect_valid = 1'b1; redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("unhalt_flag", 32'(halted), 32'h0);
        chk("unhalt_pc", pc_out, 32'h0);
        step();
        chk("unhalt_if_pc", if_pc, 32'h0);
        chk("unhalt_pc_out", pc_out, 32'h4);

        if_ready = 1'b0;
        step();
        chk("pre_async_valid", 32'(if_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(if_valid), 32'h0);
        chk("async_pc", pc_out, 32'h0);
        chk("async_instr", if_instr, NOP);
        chk("async_count", fetch_count, 32'h0);

        m_boot = 1'b1; m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
        m_halt = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            st_q.push_back('{pc: m_pc, valid: m_valid, ipc: m_ipc, instr: m_instr,
                             halted: m_halt, fault: m_fault, cnt: m_cnt});
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 10) == 0;
            tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if (($urandom % 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if_ready = rdy; redirect_valid = rv; redirect_target = tgt;
            model_step(rdy, rv, tgt);
            step();
        end
        mon_en = 1'b0;
        redirect_valid = 1'b0;
        chk("sb_residual", 32'(sb_q.size()), 32'(m_valid));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
